mac_accumulate_stage: RTL and testbench

//   Downstream stage of the 8x8 Wallace multiplier in the MAC datapath. Takes the
//   16-bit unsigned product, one per valid beat. Accumulates the beats of a frame,

---
 rtl/mac_accumulate_stage.sv | 102 ++++++++++
 tb/tb_mac_accumulate_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mac_accumulate_stage.sv
// Accumulates a frame of unsigned multiplier products and registers the frame sum, beat
// count and overflow flag for the consumer. Valid/ready handshakes are used on both sides.
module mac_accumulate_stage #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_acc;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_out_ovf;

  logic               w_accept;
  logic               w_close;
  logic [ACC_W:0]     w_prod_ext;
  logic [ACC_W:0]     w_sum;

  assign in_ready   = !(r_out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_close    = w_accept && in_last;
  assign w_prod_ext = (ACC_W + 1)'(in_prod);
  assign w_sum      = {1'b0, r_acc} + w_prod_ext;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (w_accept) begin
      unique case (r_state)
        StIdle: begin
          w_acc_nxt = w_prod_ext[ACC_W-1:0];
          w_cnt_nxt = CNT_W'(1);
          w_ovf_nxt = 1'b0;
        end
        StAccum: begin
          w_acc_nxt = w_sum[ACC_W-1:0];
          w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
          w_ovf_nxt = r_ovf | w_sum[ACC_W];
        end
        default: ;
      endcase
      w_state_nxt = in_last ? StIdle : StAccum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // A closing beat may reload the result in the same cycle the old one is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_close) begin
      r_out_valid <= 1'b1;
      r_out_acc   <= w_acc_nxt;
      r_out_cnt   <= w_cnt_nxt;
      r_out_ovf   <= w_ovf_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_count = r_out_cnt;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Directed bench for mac_accumulate_stage: hand-computed frame sums, counts and stall cases.
module tb_mac_accumulate_stage;

  localparam int unsigned PROD_W = 16;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  int n_vec = 0;
  int n_err = 0;

  mac_accumulate_stage #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [PROD_W-1:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_prod  = '0;
  endtask

  task automatic chk_result(input string tag, input logic [31:0] acc, input logic [31:0] cnt,
                            input logic ovf);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_acc"}, 32'(out_acc), acc);
    chk({tag, "_cnt"}, 32'(out_count), cnt);
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_acc", 32'(out_acc), 32'd0);
    chk("rst_cnt", 32'(out_count), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Three-beat frame.
    send(16'd100, 1'b0);
    chk("f3_no_early_valid", 32'(out_valid), 32'd0);
    send(16'd200, 1'b0);
    send(16'd300, 1'b1);
    chk_result("f3", 32'd600, 32'd3, 1'b0);
    tick();
    chk("f3_taken", 32'(out_valid), 32'd0);

    // Single-beat frame.
    send(16'd65025, 1'b1);
    chk_result("single", 32'd65025, 32'd1, 1'b0);
    tick();

    // 257 * 65535 = 16842495 -> wraps to 65279, count saturates.
    for (int i = 0; i < 256; i++) send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b1);
    chk_result("wrap", 32'd65279, 32'd255, 1'b1);
    tick();

    // Stall: result held, a pending non-last beat must not enter the frame.
    out_ready = 1'b0;
    send(16'd50, 1'b1);
    chk_result("stall0", 32'd50, 32'd1, 1'b0);
    in_valid = 1'b1;
    in_prod  = 16'd9;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_acc", 32'(out_acc), 32'd50);
      chk("stall_cnt", 32'(out_count), 32'd1);
      chk("stall_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    in_prod   = 16'd7;
    in_last   = 1'b1;
    #1;
    chk("take_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_result("take_reload", 32'd7, 32'd1, 1'b0);
    tick();
    chk("reload_taken", 32'(out_valid), 32'd0);

    // Mid-frame reset with a stale result left in the output registers.
    out_ready = 1'b0;
    send(16'd44, 1'b1);
    out_ready = 1'b1;
    send(16'd10, 1'b0);
    chk("pre_rst_acc", 32'(out_acc), 32'd44);
    send(16'd20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_acc", 32'(out_acc), 32'd0);
    chk("async_rst_cnt", 32'(out_count), 32'd0);
    chk("async_rst_ovf", 32'(out_ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(16'd5, 1'b1);
    chk_result("post_rst", 32'd5, 32'd1, 1'b0);
    tick();

    // Bubbles inside a frame.
    send(16'd1, 1'b0);
    tick();
    tick();
    tick();
    send(16'd2, 1'b0);
    tick();
    send(16'd3, 1'b1);
    chk_result("bubble", 32'd6, 32'd3, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
